// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS 32-bit CSRs, independent read and write paths.
// Define AXI_SLV_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi4_lite_slave_regs #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 8
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]            usr_regs,
  output logic [NUM_REGS-1:0]               usr_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int WA_W   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [WA_W-1:0] REG_LIMIT   = WA_W'(NUM_REGS);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}             r_state_t;

  w_state_t            w_state_q, w_state_d;
  r_state_t            r_state_q, r_state_d;
  logic                active_q;
  logic                aw_held_q, w_held_q;
  logic [WA_W-1:0]     aw_word_q;
  logic [DW-1:0]       w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DW-1:0]       rdata_q;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic                aw_fire, w_fire, ar_fire, commit, wr_en;
  logic [WA_W-1:0]     wr_word, rd_word;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic                wr_in_range, rd_in_range;
  logic [DW-1:0]       wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic                unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Whichever half arrived earlier comes from the holding register, the other straight from the bus.
  assign aw_fire     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire      = S_AXI_WVALID && S_AXI_WREADY;
  assign commit      = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign wr_word     = aw_held_q ? aw_word_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data     = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb     = w_held_q ? w_strb_q : S_AXI_WSTRB;
  assign wr_idx      = wr_word[IDX_W-1:0];
  assign wr_in_range = (wr_word < REG_LIMIT);
  assign wr_en       = commit && wr_in_range;

  assign ar_fire     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_word     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx      = rd_word[IDX_W-1:0];
  assign rd_in_range = (rd_word < REG_LIMIT);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      active_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      active_q  <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    case (w_state_q)
      W_IDLE, W_COLLECT: begin
        if (commit)                 w_state_d = W_RESP;
        else if (aw_fire || w_fire) w_state_d = W_COLLECT;
      end
      W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    case (r_state_q)
      R_IDLE:  if (ar_fire) r_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Readies come from flags only, never from same-cycle VALID; all low until out of reset.
  always_comb begin
    S_AXI_AWREADY = active_q && !aw_held_q && (w_state_q != W_RESP);
    S_AXI_WREADY  = active_q && !w_held_q && (w_state_q != W_RESP);
    S_AXI_BVALID  = (w_state_q == W_RESP);
    S_AXI_BRESP   = bresp_q;
    S_AXI_ARREADY = active_q && (r_state_q == R_IDLE);
    S_AXI_RVALID  = (r_state_q == R_DATA);
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = rresp_q;
  end

  // NOTE: the register bank is reset too: software expects known CSR values at power-up.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_word_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= commit ? 1'b0 : (aw_held_q || aw_fire);
      w_held_q  <= commit ? 1'b0 : (w_held_q || w_fire);
      if (aw_fire) aw_word_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_fire) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
`ifdef AXI_SLV_DECERR_EN
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_DECERR;
`else
        bresp_q <= RESP_OKAY;
`endif
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse_q[i] <= wr_en && (wr_idx == IDX_W'(i));
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++)
            if (wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      // Reads sample regs_q before this edge's write lands, so a same-edge read sees the old value.
      if (ar_fire) begin
        rdata_q <= rd_in_range ? regs_q[rd_idx] : '0;
`ifdef AXI_SLV_DECERR_EN
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_DECERR;
`else
        rresp_q <= RESP_OKAY;
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign usr_regs[32*g +: 32] = regs_q[g];
  end
  assign usr_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Scoreboard bench for axi4_lite_slave_regs: random and directed traffic checked against an array model.
module tb_axi4_lite_slave_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic              clk, rst_n;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [NR*32-1:0]  usr_regs;
  logic [NR-1:0]     usr_wr_pulse;

  axi4_lite_slave_regs #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .usr_regs(usr_regs), .usr_wr_pulse(usr_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]   model [NR];
  logic [1:0]    exp_b_q [$];
  logic [1:0]    exp_rresp_q [$];
  logic [31:0]   exp_rdata_q [$];
  logic [NR-1:0] exp_pulse_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < NR;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
`ifdef AXI_SLV_DECERR_EN
    return in_rng(a) ? 2'b00 : 2'b11;
`else
    return 2'b00;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 once the B handshake is done.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lag, input int w_lag, input int b_delay);
    bit aw_done = 0, w_done = 0, af, wf;
    int cyc = 0;
    logic [NR-1:0] pulse = '0;
    exp_b_q.push_back(exp_resp(addr));
    bready = (b_delay == 0);
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_lag);
      awaddr  = addr;
      awprot  = 3'($urandom);
      wvalid  = !w_done && (cyc >= w_lag);
      wdata   = data;
      wstrb   = strb;
      @(negedge clk);
      check("awready", awready, !aw_done);
      check("wready", wready, !w_done);
      check("bvalid_before_commit", bvalid, 1'b0);
      af = awvalid && awready;
      wf = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= af;
      w_done  |= wf;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_timeout", 1'b0, 1'b1);
      void'(exp_b_q.pop_back());
      bready = 1'b1;
      return;
    end
    if (in_rng(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr >> 2][8*b +: 8] = data[8*b +: 8];
      pulse[addr >> 2] = 1'b1;
    end
    exp_pulse_q.push_back(pulse);
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      check("bvalid_held", bvalid, 1'b1);
      check("awready_during_b", awready, 1'b0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    check("bvalid_at_handshake", bvalid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid_drop", bvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  // Expected data is taken from the model just before the AR edge, so a same-edge commit is unseen.
  task automatic do_read(input logic [31:0] addr, input int r_delay, input int ar_lag);
    bit done = 0;
    int cyc = 0;
    rready = (r_delay == 0);
    while (!done && cyc < 50) begin
      arvalid = (cyc >= ar_lag);
      araddr  = addr;
      arprot  = 3'($urandom);
      @(negedge clk);
      check("arready_idle", arready, 1'b1);
      if (arvalid && arready) begin
        exp_rdata_q.push_back(in_rng(addr) ? model[addr >> 2] : 32'h0);
        exp_rresp_q.push_back(exp_resp(addr));
        done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    if (!done) begin
      check("read_timeout", 1'b0, 1'b1);
      rready = 1'b1;
      return;
    end
    for (int i = 0; i < r_delay; i++) begin
      @(negedge clk);
      check("rvalid_held", rvalid, 1'b1);
      check("arready_busy", arready, 1'b0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(negedge clk);
    check("rvalid_at_handshake", rvalid, 1'b1);
    check("arready_busy", arready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rvalid_drop", rvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on each handshake and watches stability while stalled.
  logic        prev_bv, prev_bstall, prev_rstall;
  logic [1:0]  prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_bv = 1'b0; prev_bstall = 1'b0; prev_rstall = 1'b0;
    end else begin
      if (bvalid && !prev_bv) begin
        if (exp_pulse_q.size() == 0) check("pulse_unexpected_b", 1'b1, 1'b0);
        else check("wr_pulse", usr_wr_pulse, exp_pulse_q.pop_front());
        check("usr_regs", usr_regs, model_flat());
      end else begin
        check("pulse_idle", usr_wr_pulse, '0);
      end
      if (bvalid && prev_bstall) check("bresp_stable", bresp, prev_bresp);
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 1'b1, 1'b0);
        else check("bresp", bresp, exp_b_q.pop_front());
      end
      if (rvalid && prev_rstall) begin
        check("rdata_stable", rdata, prev_rdata);
        check("rresp_stable", rresp, prev_rresp);
      end
      if (rvalid && rready) begin
        if (exp_rdata_q.size() == 0) check("r_unexpected", 1'b1, 1'b0);
        else begin
          check("rdata", rdata, exp_rdata_q.pop_front());
          check("rresp", rresp, exp_rresp_q.pop_front());
        end
      end
      prev_bv     = bvalid;
      prev_bstall = bvalid && !bready;
      prev_bresp  = bresp;
      prev_rstall = rvalid && !rready;
      prev_rdata  = rdata;
      prev_rresp  = rresp;
    end
  end

  task automatic check_reset_outputs();
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_usr_regs", usr_regs, '0);
    check("rst_pulse", usr_wr_pulse, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg1_deadbeef", usr_regs[63:32], 32'hDEADBEEF);
    do_write(32'h08, 32'h11223344, 4'h5, 3, 0, 5);
    check("reg2_strobed", usr_regs[95:64], 32'h00220044);
    do_read(32'h04, 4, 0);

    fork
      do_write(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      do_read(32'h0C, 0, 0);
    join
    do_read(32'h0C, 0, 0);

    do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 1);
    do_read(32'h40, 1, 0);
    do_write(32'h17, 32'h0BADF00D, 4'h0, 1, 0, 0);
    do_write(32'h1E, 32'hCAFE0001, 4'hC, 0, 2, 0);
    do_read(32'h1D, 0, 2);

    for (int it = 0; it < 60; it++) begin
      logic [31:0] wa, ra, d;
      logic [3:0]  s;
      int kind;
      wa   = ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      ra   = ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      d    = $urandom;
      s    = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 2);
      if (kind == 0)
        do_write(wa, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (kind == 1)
        do_read(ra, $urandom_range(0, 3), $urandom_range(0, 2));
      else
        fork
          do_write(wa, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3));
        join
    end

    // Leave a B and an R pending, then pull reset mid-cycle.
    bready = 1'b0; rready = 1'b0;
    awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h04;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[4] = 32'h55AA55AA;
    exp_pulse_q.push_back(8'h10);
    @(negedge clk);
    check("pending_bvalid", bvalid, 1'b1);
    check("pending_rvalid", rvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    exp_b_q.delete(); exp_rdata_q.delete(); exp_rresp_q.delete(); exp_pulse_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(32'h10, 0, 0);
    do_read(32'h04, 0, 0);

    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_rdata_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
